gray_decode_tracker: RTL and testbench

Receive-side companion to the team's binary-to-Gray counter. Takes a WIDTH-bit Gray-coded count, optionally from another clock domain, and optionally synchronizes it. Decodes it to binary and tracks motion: single-step up/down pulses, multi-bit jump (skip) detection, and a saturating error counter. Sits at the consumer end of any Gray-coded pointer or position bus.

---
 rtl/gray_decode_tracker.sv | 118 +++++++++++
 tb/tb_gray_decode_tracker.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/gray_decode_tracker.sv
// Gray-code receiver: capture (optionally synchronized via GRAY_DEC_SYNC_EN), decode to binary,
// and track motion with up/down/skip pulses plus a saturating skip counter.
module gray_decode_tracker #(
  parameter int WIDTH       = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             enable,
  input  logic [WIDTH-1:0] gray_in,
  output logic [WIDTH-1:0] bin_out,
  output logic             bin_valid,
  output logic             up,
  output logic             down,
  output logic             skip_err,
  output logic [7:0]       err_cnt
);

  if (WIDTH < 2 || SYNC_STAGES < 2) begin : g_param_check
    $error("gray_decode_tracker: WIDTH and SYNC_STAGES must both be >= 2");
  end

  logic [WIDTH-1:0] gray_s;

`ifdef GRAY_DEC_SYNC_EN
  // Plain flop chain; gray_in may be asynchronous because only one bit changes per step.
  logic [SYNC_STAGES-1:0][WIDTH-1:0] sync_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_reg <= '0;
    end else begin
      sync_reg <= {sync_reg[SYNC_STAGES-2:0], gray_in};
    end
  end

  assign gray_s = sync_reg[SYNC_STAGES-1];
`else
  logic [WIDTH-1:0] capture_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      capture_reg <= '0;
    end else begin
      capture_reg <= gray_in;
    end
  end

  assign gray_s = capture_reg;
`endif

  // Each binary bit is the XOR of all Gray bits at or above it.
  logic [WIDTH-1:0] bin_dec;

  for (genvar gi = 0; gi < WIDTH; gi++) begin : g_decode
    assign bin_dec[gi] = ^gray_s[WIDTH-1:gi];
  end

  localparam logic [WIDTH-1:0] STEP_UP   = {{(WIDTH-1){1'b0}}, 1'b1};
  localparam logic [WIDTH-1:0] STEP_DOWN = {WIDTH{1'b1}};

  logic [WIDTH-1:0] delta;
  assign delta = bin_dec - bin_out;

  typedef enum logic {
    UNPRIMED = 1'b0,
    TRACK    = 1'b1
  } state_t;

  state_t state_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= UNPRIMED;
      bin_out   <= '0;
      bin_valid <= 1'b0;
      up        <= 1'b0;
      down      <= 1'b0;
      skip_err  <= 1'b0;
      err_cnt   <= '0;
    end else begin
      up       <= 1'b0;
      down     <= 1'b0;
      skip_err <= 1'b0;
      case (state_reg)
        UNPRIMED: begin
          if (enable) begin
            bin_out   <= bin_dec;
            bin_valid <= 1'b1;
            state_reg <= TRACK;
          end else begin
            bin_valid <= 1'b0;
          end
        end
        TRACK: begin
          if (!enable) begin
            bin_valid <= 1'b0;
            state_reg <= UNPRIMED;
          end else if (delta != '0) begin
            bin_out <= bin_dec;
            if (delta == STEP_UP) begin
              up <= 1'b1;
            end else if (delta == STEP_DOWN) begin
              down <= 1'b1;
            end else begin
              skip_err <= 1'b1;
              if (err_cnt != 8'hFF) begin
                err_cnt <= err_cnt + 8'd1;
              end
            end
          end
        end
        default: state_reg <= UNPRIMED;
      endcase
    end
  end

endmodule

// File: tb/tb_gray_decode_tracker.sv
// Scoreboard bench for gray_decode_tracker; expected outputs come from a behavioural model
// that tracks the capture latency of whichever build is compiled.
`timescale 1ns/1ps
module tb_gray_decode_tracker;

`ifdef GRAY_DEC_SYNC_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       enable = 1'b0;
  logic [7:0] gray_in = 8'h00;
  logic [7:0] bin_out;
  logic       bin_valid, up, down, skip_err;
  logic [7:0] err_cnt;

  gray_decode_tracker #(.WIDTH(8), .SYNC_STAGES(2)) dut (
    .clk(clk), .rst(rst), .enable(enable), .gray_in(gray_in),
    .bin_out(bin_out), .bin_valid(bin_valid), .up(up), .down(down),
    .skip_err(skip_err), .err_cnt(err_cnt)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [7:0] bin;
    logic       valid;
    logic       up;
    logic       down;
    logic       skip;
    logic [7:0] err;
  } obs_t;

  int checks = 0;
  int passed = 0;

  obs_t       sb[$];
  logic [7:0] ghist[$];
  logic       m_primed = 1'b0;
  logic [7:0] m_bin = 8'h00;
  logic [7:0] m_err = 8'h00;

  function automatic logic [7:0] bin2gray(input logic [7:0] b);
    return b ^ (b >> 1);
  endfunction

  function automatic logic [7:0] gray2bin(input logic [7:0] g);
    logic [7:0] b = 8'h00;
    for (logic [7:0] v = g; v != 8'h00; v = v >> 1) b = b ^ v;
    return b;
  endfunction

  function automatic string fmt(input obs_t o);
    return $sformatf("bin=%02h v=%b up=%b dn=%b skip=%b err=%0d",
                     o.bin, o.valid, o.up, o.down, o.skip, o.err);
  endfunction

  // Drive one cycle, push the model's expectation, then sample the DUT after the edge.
  task automatic step(input logic r, input logic e, input logic [7:0] g,
                      output obs_t o, output obs_t x);
    obs_t       m;
    logic [7:0] d, delta;
    @(negedge clk);
    rst = r; enable = e; gray_in = g;
    m = '0;
    if (r) begin
      m_primed = 1'b0; m_bin = 8'h00; m_err = 8'h00;
      ghist.delete();
      for (int i = 0; i < LAT; i++) ghist.push_back(8'h00);
    end else begin
      d = gray2bin(ghist.pop_front());
      ghist.push_back(g);
      if (!e) begin
        m_primed = 1'b0;
      end else if (!m_primed) begin
        m_bin = d; m_primed = 1'b1;
      end else begin
        delta = d - m_bin;
        if (delta == 8'd1) m.up = 1'b1;
        else if (delta == 8'hFF) m.down = 1'b1;
        else if (delta != 8'd0) begin
          m.skip = 1'b1;
          if (m_err != 8'hFF) m_err = m_err + 8'd1;
        end
        m_bin = d;
      end
      m.bin = m_bin; m.valid = m_primed; m.err = m_err;
    end
    sb.push_back(m);
    @(posedge clk);
    #1;
    o = {bin_out, bin_valid, up, down, skip_err, err_cnt};
    x = sb.pop_front();
  endtask

  task automatic test_reset();
    obs_t o, x;
    for (int i = 0; i < 2; i++) begin
      step(1'b1, 1'b1, 8'h5A, o, x);
      checks++;
      if (o !== x) $display("FAIL reset c%0d: got %s want %s", i, fmt(o), fmt(x));
      else passed++;
    end
    checks++;
    if (o !== obs_t'(0)) $display("FAIL reset_zero: got %s want all zero", fmt(o));
    else passed++;
  endtask

  task automatic test_prime();
    obs_t o, x;
    step(1'b1, 1'b0, 8'h00, o, x);
    for (int i = 0; i < LAT + 1; i++) begin
      step(1'b0, 1'b1, 8'h00, o, x);
      checks++;
      if (o !== x) $display("FAIL prime c%0d: got %s want %s", i, fmt(o), fmt(x));
      else passed++;
    end
    checks++;
    if (!(o.valid === 1'b1 && o.bin === 8'h00 && {o.up, o.down, o.skip} === 3'b000))
      $display("FAIL prime_final: got %s want bin=00 v=1 no pulse", fmt(o));
    else passed++;
  endtask

  task automatic test_up_sweep();
    obs_t o, x;
    int   ups = 0, skips = 0;
    step(1'b1, 1'b0, 8'h00, o, x);
    for (int i = 0; i < LAT + 1; i++) step(1'b0, 1'b1, 8'h00, o, x);
    for (int k = 1; k <= 256 + LAT; k++) begin
      step(1'b0, 1'b1, (k <= 256) ? bin2gray(8'(k)) : 8'h00, o, x);
      ups += o.up; skips += o.skip;
      checks++;
      if (o !== x) $display("FAIL up_sweep k%0d: got %s want %s", k, fmt(o), fmt(x));
      else passed++;
    end
    checks++;
    if (ups != 256 || skips != 0 || o.err !== 8'd0 || o.bin !== 8'h00)
      $display("FAIL up_sweep_total: got ups=%0d skips=%0d %s want ups=256 skips=0 bin=00 err=0",
               ups, skips, fmt(o));
    else passed++;
  endtask

  task automatic test_down_step();
    obs_t       o, x;
    int         downs = 0;
    logic [7:0] seq[3] = '{8'h03, 8'h01, 8'h00};
    step(1'b1, 1'b0, 8'h03, o, x);
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 8'h03, o, x);
    for (int s = 0; s < 3; s++) begin
      for (int i = 0; i < 3; i++) begin
        step(1'b0, 1'b1, seq[s], o, x);
        downs += o.down;
        checks++;
        if (o !== x) $display("FAIL down s%0d c%0d: got %s want %s", s, i, fmt(o), fmt(x));
        else passed++;
      end
    end
    checks++;
    if (downs != 2 || o.bin !== 8'h00 || o.err !== 8'd0)
      $display("FAIL down_total: got downs=%0d %s want downs=2 bin=00 err=0", downs, fmt(o));
    else passed++;
  endtask

  task automatic test_skip();
    obs_t o, x;
    int   skips = 0, ups = 0;
    step(1'b1, 1'b0, 8'h00, o, x);
    for (int i = 0; i < LAT + 1; i++) step(1'b0, 1'b1, 8'h00, o, x);
    for (int i = 0; i < LAT + 2; i++) begin
      step(1'b0, 1'b1, 8'h03, o, x);
      skips += o.skip; ups += o.up;
      checks++;
      if (o !== x) $display("FAIL skip c%0d: got %s want %s", i, fmt(o), fmt(x));
      else passed++;
    end
    checks++;
    if (skips != 1 || ups != 0 || o.err !== 8'd1 || o.bin !== 8'h02)
      $display("FAIL skip_total: got skips=%0d ups=%0d %s want 1 skip bin=02 err=1",
               skips, ups, fmt(o));
    else passed++;
  endtask

  task automatic test_saturation_enable();
    obs_t o, x;
    step(1'b1, 1'b0, 8'h00, o, x);
    for (int i = 0; i < LAT + 1; i++) step(1'b0, 1'b1, 8'h00, o, x);
    for (int i = 0; i < 300 + LAT; i++) begin
      step(1'b0, 1'b1, (i < 300 && i % 2 == 0) ? 8'h03 : 8'h00, o, x);
      checks++;
      if (o !== x) $display("FAIL saturate i%0d: got %s want %s", i, fmt(o), fmt(x));
      else passed++;
    end
    checks++;
    if (o.err !== 8'd255) $display("FAIL saturate_cnt: got err=%0d want 255", o.err);
    else passed++;
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 1'b0, 8'h40, o, x);
      checks++;
      if (o !== x || o.valid !== 1'b0)
        $display("FAIL disabled c%0d: got %s want %s", i, fmt(o), fmt(x));
      else passed++;
    end
    for (int i = 0; i < LAT + 1; i++) begin
      step(1'b0, 1'b1, 8'h40, o, x);
      checks++;
      if (o !== x) $display("FAIL reprime c%0d: got %s want %s", i, fmt(o), fmt(x));
      else passed++;
    end
    checks++;
    if (!(o.bin === 8'h7F && o.valid === 1'b1 && {o.up, o.down, o.skip} === 3'b000 && o.err === 8'd255))
      $display("FAIL reprime_final: got %s want bin=7f v=1 no pulse err=255", fmt(o));
    else passed++;
  endtask

  task automatic test_reset_mid();
    obs_t o, x;
    int   k = 0;
    step(1'b1, 1'b0, 8'h00, o, x);
    for (int i = 0; i < LAT + 1; i++) step(1'b0, 1'b1, 8'h00, o, x);
    // Bounded sweep: bin_out should reach 0x40 well within 100 steps.
    while (o.bin !== 8'h40 && k < 100) begin
      k++;
      step(1'b0, 1'b1, bin2gray(8'(k)), o, x);
      checks++;
      if (o !== x) $display("FAIL mid_sweep k%0d: got %s want %s", k, fmt(o), fmt(x));
      else passed++;
    end
    checks++;
    if (o.bin !== 8'h40) $display("FAIL mid_reach: got bin=%02h want 40 within budget", o.bin);
    else passed++;
    step(1'b1, 1'b1, bin2gray(8'(k + 1)), o, x);
    checks++;
    if (o !== x || o !== obs_t'(0)) $display("FAIL mid_reset: got %s want all zero", fmt(o));
    else passed++;
    step(1'b0, 1'b1, bin2gray(8'(k + 2)), o, x);
    checks++;
    if (o !== x || o.valid !== 1'b1 || {o.up, o.down, o.skip} !== 3'b000)
      $display("FAIL mid_reprime: got %s want %s (no pulse)", fmt(o), fmt(x));
    else passed++;
    for (int i = 0; i < 4; i++) begin
      step(1'b0, 1'b1, bin2gray(8'(k + 3 + i)), o, x);
      checks++;
      if (o !== x) $display("FAIL mid_after c%0d: got %s want %s", i, fmt(o), fmt(x));
      else passed++;
    end
  endtask

  initial begin
    test_reset();
    test_prime();
    test_up_sweep();
    test_down_step();
    test_skip();
    test_saturation_enable();
    test_reset_mid();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
